// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_pkg: shared state codes, error codes and command bytes for PS/2 host   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_INHIBIT = 3'd1;
    localparam state_t S_START   = 3'd2;
    localparam state_t S_SHIFT   = 3'd3;
    localparam state_t S_ACK     = 3'd4;
    localparam state_t S_RELEASE = 3'd5;

    typedef logic [1:0] err_t;

    localparam err_t E_OK        = 2'd0;
    localparam err_t E_START_TMO = 2'd1;
    localparam err_t E_XFER_TMO  = 2'd2;
    localparam err_t E_NOACK     = 2'd3;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Odd parity bit: makes the total count of ones across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_line_sync: 2-FF synchronizer for PS2_CLK/PS2_DAT, CLK falling detect   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fall
);

    logic [1:0] r_clk_pipe;
    logic [1:0] r_dat_pipe;
    logic       r_clk_prev;

    // Idle lines are pulled high, so reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_pipe <= 2'b11;
            r_dat_pipe <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_pipe <= {r_clk_pipe[0], i_ps2_clk};
            r_dat_pipe <= {r_dat_pipe[0], i_ps2_dat};
            r_clk_prev <= r_clk_pipe[1];
        end
    end

    assign o_clk_sync = r_clk_pipe[1];
    assign o_dat_sync = r_dat_pipe[1];
    assign o_clk_fall = r_clk_prev & ~r_clk_pipe[1];

endmodule : ps2_line_sync
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_host_tx: PS/2 host-to-device command byte transmitter (open-drain oe)  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 12,
    parameter int START_TMO   = 1500,
    parameter int XFER_TMO    = 200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_rx_inhibit,
    output logic       o_done,
    output logic [1:0] o_err,
    output logic [2:0] o_state
);

    localparam int c_cnt_max = (START_TMO > INHIBIT_CYC) ? START_TMO : INHIBIT_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_xfer_w  = $clog2(XFER_TMO + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_inh_pre   = c_cnt_w'(INHIBIT_CYC - 2);
    localparam logic [c_cnt_w-1:0]  c_inh_last  = c_cnt_w'(INHIBIT_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_start_last = c_cnt_w'(START_TMO - 1);
    localparam logic [c_xfer_w-1:0] c_xfer_one  = c_xfer_w'(1);
    localparam logic [c_xfer_w-1:0] c_xfer_last = c_xfer_w'(XFER_TMO - 1);
    localparam logic [3:0]          c_stop_idx  = 4'd9;

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_clk_fall;

    state_t                r_state,  w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt,    w_cnt_nxt;
    logic [c_xfer_w-1:0]   r_xfer,   w_xfer_nxt;
    logic [3:0]            r_bits,   w_bits_nxt;
    logic [9:0]            r_frame,  w_frame_nxt;
    logic                  r_clk_oe, w_clk_oe_nxt;
    logic                  r_dat_oe, w_dat_oe_nxt;
    logic                  r_done,   w_done_nxt;
    err_t                  r_err,    w_err_nxt;

    ps2_line_sync u_line_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_dat  (i_ps2_dat),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_clk_fall)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_xfer   <= '0;
            r_bits   <= '0;
            r_frame  <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= E_OK;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_xfer   <= w_xfer_nxt;
            r_bits   <= w_bits_nxt;
            r_frame  <= w_frame_nxt;
            r_clk_oe <= w_clk_oe_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_xfer_nxt   = r_xfer;
        w_bits_nxt   = r_bits;
        w_frame_nxt  = r_frame;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (i_valid) begin
                    w_state_nxt  = S_INHIBIT;
                    w_cnt_nxt    = '0;
                    w_xfer_nxt   = '0;
                    w_bits_nxt   = '0;
                    w_frame_nxt  = {1'b1, odd_parity(i_data), i_data};
                    w_err_nxt    = E_OK;
                    w_clk_oe_nxt = 1'b1;
                end
            end

            S_INHIBIT: begin
                w_cnt_nxt = r_cnt + c_cnt_one;
                // Start bit goes low one cycle before CLK is released.
                if (r_cnt == c_inh_pre) begin
                    w_dat_oe_nxt = 1'b1;
                end
                if (r_cnt == c_inh_last) begin
                    w_state_nxt  = S_START;
                    w_cnt_nxt    = '0;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b1;
                end
            end

            S_START: begin
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame[0];
                    w_frame_nxt  = {1'b1, r_frame[9:1]};
                    w_bits_nxt   = 4'd1;
                    w_xfer_nxt   = '0;
                    w_state_nxt  = S_SHIFT;
                end else if (r_cnt == c_start_last) begin
                    w_err_nxt    = E_START_TMO;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_state_nxt  = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end

            S_SHIFT: begin
                w_xfer_nxt = r_xfer + c_xfer_one;
                if (w_clk_fall) begin
                    w_dat_oe_nxt = ~r_frame[0];
                    w_frame_nxt  = {1'b1, r_frame[9:1]};
                    w_bits_nxt   = r_bits + 4'd1;
                    if (r_bits == c_stop_idx) begin
                        w_state_nxt = S_ACK;
                    end
                end else if (r_xfer == c_xfer_last) begin
                    w_err_nxt    = E_XFER_TMO;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_state_nxt  = S_RELEASE;
                end
            end

            S_ACK: begin
                w_xfer_nxt = r_xfer + c_xfer_one;
                if (w_clk_fall) begin
                    w_err_nxt    = w_dat_sync ? E_NOACK : E_OK;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_state_nxt  = S_RELEASE;
                end else if (r_xfer == c_xfer_last) begin
                    w_err_nxt    = E_XFER_TMO;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                    w_state_nxt  = S_RELEASE;
                end
            end

            S_RELEASE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                // Timeouts finish at once; otherwise wait for the device to free both lines.
                if ((r_err == E_START_TMO) || (r_err == E_XFER_TMO)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_clk_sync && w_dat_sync) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_xfer == c_xfer_last) begin
                    w_err_nxt   = E_XFER_TMO;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_xfer_nxt = r_xfer + c_xfer_one;
                end
            end

            default: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign o_ready      = (r_state == S_IDLE);
    assign o_rx_inhibit = (r_state != S_IDLE);
    assign o_ps2_clk_oe = r_clk_oe;
    assign o_ps2_dat_oe = r_dat_oe;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_state      = r_state;

endmodule : ps2_host_tx
`default_nettype wire
